// File: rtl/layer_sequencer.sv
// layer_sequencer: control FSM that walks the two-cache router through a multi-layer pass.
//
// Optional watchdog: define LAYERSEQ_TIMEOUT_EN to abandon a layer that runs for
// TIMEOUT_CYCLES RUN cycles without proc_Done (sets sticky err).
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   user_Start          start request, sampled only in IDLE
//   user_NumLayers      layer count, latched at start
//   user_FirstSecond    cache holding the input, latched at start
//   user_Abort          abandon the pass from GUARD/RUN/SWAP
//   user_Busy           high from start acceptance through DONE
//   user_Done           one-cycle completion pulse
//   user_ResultSecond   cache holding the final output, valid with user_Done
//   proc_Start          one-cycle pulse at the start of each layer
//   proc_Done           layer-complete pulse from the processors
//   proc_Layer          current layer index
//   critical            router select: processors own the caches
//   cacheSecond         router select: source cache for processor reads
//   ReverseWrite        router select: processor writes go to the non-source cache
//   err                 sticky watchdog error
module layer_sequencer #(
    parameter int LAYER_W        = 8,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               user_Start,
    input  logic [LAYER_W-1:0] user_NumLayers,
    input  logic               user_FirstSecond,
    input  logic               user_Abort,
    output logic               user_Busy,
    output logic               user_Done,
    output logic               user_ResultSecond,
    output logic               proc_Start,
    input  logic               proc_Done,
    output logic [LAYER_W-1:0] proc_Layer,
    output logic               critical,
    output logic               cacheSecond,
    output logic               ReverseWrite,
    output logic               err
);
    typedef enum logic [2:0] {IDLE, GUARD, RUN, SWAP, DONE} state_t;

    state_t             state_q, state_d;
    logic [LAYER_W-1:0] num_q, num_d, layer_q, layer_d;
    logic               cs_q, cs_d;
    logic [3:0]         settle_q, settle_d;
    logic               crit_q, rw_q, busy_q, done_q, start_q, result_q;
`ifdef LAYERSEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        layer_d  = layer_q;
        cs_d     = cs_q;
        settle_d = (state_q == GUARD) ? settle_q + 4'd1 : 4'd0;
`ifdef LAYERSEQ_TIMEOUT_EN
        wd_d     = (state_q == RUN) ? wd_q + 1'b1 : '0;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (user_Start) begin
                    num_d   = user_NumLayers;
                    cs_d    = user_FirstSecond;
                    layer_d = '0;
                    state_d = (user_NumLayers == '0) ? DONE : GUARD;
`ifdef LAYERSEQ_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            GUARD: state_d = (settle_q == 4'(SETTLE_CYCLES - 1)) ? RUN : GUARD;
            RUN: begin
                // start_q marks the first RUN cycle, where proc_Done is not yet honoured
                if (!start_q && proc_Done) begin
                    cs_d    = ~cs_q;
                    layer_d = layer_q + 1'b1;
                    state_d = SWAP;
                end
`ifdef LAYERSEQ_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            SWAP: state_d = (layer_q == num_q) ? DONE : GUARD;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // abort wins over proc_Done and the watchdog: undo anything the case above staged
        if (user_Abort && (state_q inside {GUARD, RUN, SWAP})) begin
            state_d = IDLE;
            cs_d    = cs_q;
            layer_d = layer_q;
`ifdef LAYERSEQ_TIMEOUT_EN
            err_d   = err_q;
`endif
        end
    end

    // outputs are registered from the next state so they change exactly with the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            num_q    <= '0;
            layer_q  <= '0;
            cs_q     <= 1'b0;
            settle_q <= '0;
            crit_q   <= 1'b0;
            rw_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            result_q <= 1'b0;
`ifdef LAYERSEQ_TIMEOUT_EN
            wd_q     <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            layer_q  <= layer_d;
            cs_q     <= cs_d;
            settle_q <= settle_d;
            crit_q   <= state_d inside {GUARD, RUN, SWAP};
            rw_q     <= state_d inside {GUARD, RUN};
            busy_q   <= state_d != IDLE;
            done_q   <= state_d == DONE;
            start_q  <= (state_d == RUN) && (state_q != RUN);
            result_q <= (state_d == DONE) ? cs_d : result_q;
`ifdef LAYERSEQ_TIMEOUT_EN
            wd_q     <= wd_d;
            err_q    <= err_d;
`endif
        end
    end

    assign user_Busy         = busy_q;
    assign user_Done         = done_q;
    assign user_ResultSecond = result_q;
    assign proc_Start        = start_q;
    assign proc_Layer        = layer_q;
    assign critical          = crit_q;
    assign cacheSecond       = cs_q;
    assign ReverseWrite      = rw_q;
`ifdef LAYERSEQ_TIMEOUT_EN
    assign err = err_q;
`else
    // no watchdog: constant 0, written against the parameter so it stays referenced
    assign err = TIMEOUT_CYCLES < 0;
`endif
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: randomized + directed bench with a pass-level reference model.
module tb_layer_sequencer;
    localparam int LW = 8;
    localparam int S  = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          user_Start = 1'b0;
    logic [LW-1:0] user_NumLayers = '0;
    logic          user_FirstSecond = 1'b0;
    logic          user_Abort = 1'b0;
    logic          proc_Done = 1'b0;
    logic          user_Busy, user_Done, user_ResultSecond, proc_Start;
    logic [LW-1:0] proc_Layer;
    logic          critical, cacheSecond, ReverseWrite, err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    layer_sequencer #(.LAYER_W(LW), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .user_Start(user_Start), .user_NumLayers(user_NumLayers),
        .user_FirstSecond(user_FirstSecond), .user_Abort(user_Abort),
        .user_Busy(user_Busy), .user_Done(user_Done), .user_ResultSecond(user_ResultSecond),
        .proc_Start(proc_Start), .proc_Done(proc_Done), .proc_Layer(proc_Layer),
        .critical(critical), .cacheSecond(cacheSecond), .ReverseWrite(ReverseWrite), .err(err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Pass-level model: a pass is a sequence of layer segments (S settle cycles, then
    // run cycles), each followed by one swap cycle, then one done cycle.
    bit          armed = 0;
    bit          m_seg, m_swap, m_done, m_cs, m_res, m_err;
    int          m_k;
    logic [LW-1:0] m_num, m_layer;

    always @(posedge clk) begin
        if (rst) begin
            armed = 1; m_seg = 0; m_swap = 0; m_done = 0; m_cs = 0; m_res = 0; m_err = 0;
            m_k = 0; m_num = '0; m_layer = '0;
        end else if (m_done) m_done = 0;
        else if (!m_seg && !m_swap) begin
            if (user_Start) begin
                m_num = user_NumLayers; m_cs = user_FirstSecond; m_layer = '0; m_err = 0;
                if (user_NumLayers == 0) begin m_done = 1; m_res = m_cs; end
                else begin m_seg = 1; m_k = 0; end
            end
        end else if (user_Abort) begin m_seg = 0; m_swap = 0; end
        else if (m_swap) begin
            m_swap = 0;
            if (m_layer == m_num) begin m_done = 1; m_res = m_cs; end
            else begin m_seg = 1; m_k = 0; end
        end else if (m_k > S && proc_Done) begin
            m_cs = !m_cs; m_layer = m_layer + 1'b1; m_seg = 0; m_swap = 1;
        end
`ifdef LAYERSEQ_TIMEOUT_EN
        else if (m_k == S + TO - 1) begin m_err = 1; m_seg = 0; end
`endif
        else m_k++;
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("critical", critical, int'(m_seg | m_swap));
            chk("ReverseWrite", ReverseWrite, int'(m_seg));
            chk("user_Busy", user_Busy, int'(m_seg | m_swap | m_done));
            chk("user_Done", user_Done, int'(m_done));
            chk("proc_Start", proc_Start, int'(m_seg && m_k == S));
            chk("proc_Layer", int'(proc_Layer), int'(m_layer));
            chk("cacheSecond", cacheSecond, int'(m_cs));
            chk("err", err, int'(m_err));
            if (m_done) chk("user_ResultSecond", user_ResultSecond, int'(m_res));
        end
    end

    task automatic start_pass(input int n, input bit fs);
        user_NumLayers = LW'(n); user_FirstSecond = fs; user_Start = 1'b1;
        @(negedge clk);
        user_Start = 1'b0;
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        while (!proc_Start && n < 60) begin @(negedge clk); n++; end
        chk(nm, proc_Start, 1);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!user_Done && n < 60) begin @(negedge clk); n++; end
        chk(nm, user_Done, 1);
    endtask

    task automatic pulse_done();
        proc_Done = 1'b1; @(negedge clk); proc_Done = 1'b0;
    endtask

    initial begin
        int n_st, n_done, n_swap, crit_gap, first_lat, cd, cyc_n;
        int lay[3], csv[3];
        bit res;
        // reset with random inputs
        repeat (2) begin
            user_Start = 1'($urandom); user_NumLayers = LW'($urandom); user_FirstSecond = 1'($urandom);
            user_Abort = 1'($urandom); proc_Done = 1'($urandom);
            @(negedge clk);
        end
        chk("rst_busy", user_Busy, 0);
        chk("rst_critical", critical, 0);
        chk("rst_start", proc_Start, 0);
        rst = 1'b0; user_Start = 0; user_Abort = 0; proc_Done = 0; user_NumLayers = '0; user_FirstSecond = 0;
        @(negedge clk);
        chk("idle_critical", critical, 0);
        chk("idle_busy", user_Busy, 0);

        // normal pass: 3 layers, proc_Done 5 cycles after each proc_Start
        start_pass(3, 0);
        n_st = 0; n_done = 0; n_swap = 0; crit_gap = 0; first_lat = 0; cd = 0; cyc_n = 1; res = 0;
        for (int i = 0; i < 200; i++) begin
            proc_Done = 1'b0;
            if (cd > 0) begin cd--; if (cd == 0) proc_Done = 1'b1; end
            if (proc_Start) begin
                if (n_st == 0) first_lat = cyc_n;
                if (n_st < 3) begin lay[n_st] = int'(proc_Layer); csv[n_st] = int'(cacheSecond); end
                n_st++; cd = 5;
            end
            if (critical && !ReverseWrite) n_swap++;
            if (!user_Done && !critical) crit_gap++;
            if (user_Done) begin n_done++; res = user_ResultSecond; break; end
            @(negedge clk); cyc_n++;
        end
        proc_Done = 1'b0;
        chk("pass_starts", n_st, 3);
        chk("pass_layer0", lay[0], 0);
        chk("pass_layer1", lay[1], 1);
        chk("pass_layer2", lay[2], 2);
        chk("pass_cs0", csv[0], 0);
        chk("pass_cs1", csv[1], 1);
        chk("pass_cs2", csv[2], 0);
        chk("pass_swaps", n_swap, 3);
        chk("pass_done", n_done, 1);
        chk("pass_result", int'(res), 1);
        chk("pass_latency", first_lat, 3);
        chk("pass_critical_gap", crit_gap, 0);
        @(negedge clk);

        // zero layers
        start_pass(0, 1);
        chk("zero_done", user_Done, 1);
        chk("zero_result", user_ResultSecond, 1);
        chk("zero_critical", critical, 0);
        chk("zero_start", proc_Start, 0);
        @(negedge clk);
        chk("zero_idle", user_Busy, 0);

        // abort in RUN of layer 1 together with proc_Done
        start_pass(3, 0);
        wait_start("abort_l0_start");
        @(negedge clk);
        pulse_done();
        wait_start("abort_l1_start");
        chk("abort_l1_layer", int'(proc_Layer), 1);
        @(negedge clk);
        proc_Done = 1'b1; user_Abort = 1'b1;
        @(negedge clk);
        proc_Done = 1'b0; user_Abort = 1'b0;
        chk("abort_busy", user_Busy, 0);
        chk("abort_critical", critical, 0);
        chk("abort_rw", ReverseWrite, 0);
        chk("abort_done", user_Done, 0);
        chk("abort_layer", int'(proc_Layer), 1);
        chk("abort_cs", cacheSecond, 1);

        // restart from layer 0, with ignored events along the way
        start_pass(2, 1);
        chk("restart_layer", int'(proc_Layer), 0);
        chk("restart_busy", user_Busy, 1);
        pulse_done();
        chk("guard_done_ignored_rw", ReverseWrite, 1);
        chk("guard_done_ignored_start", proc_Start, 0);
        wait_start("restart_l0_start");
        user_Start = 1'b1; user_NumLayers = LW'(7); user_FirstSecond = 1'b0;
        @(negedge clk);
        user_Start = 1'b0;
        chk("run_start_ignored_start", proc_Start, 0);
        chk("run_start_ignored_busy", user_Busy, 1);
        chk("run_start_ignored_layer", int'(proc_Layer), 0);
        chk("run_start_ignored_cs", cacheSecond, 1);
        pulse_done();
        wait_start("restart_l1_start");
        @(negedge clk);
        pulse_done();
        wait_done("restart_done");
        chk("restart_result", user_ResultSecond, 1);
        @(negedge clk);
        pulse_done();
        chk("idle_done_ignored_busy", user_Busy, 0);
        chk("idle_done_ignored_layer", int'(proc_Layer), 2);

        // watchdog
        start_pass(1, 0);
        wait_start("wd_start");
        repeat (TO + 4) @(negedge clk);
`ifdef LAYERSEQ_TIMEOUT_EN
        chk("wd_err", err, 1);
        chk("wd_critical", critical, 0);
        chk("wd_busy", user_Busy, 0);
        start_pass(1, 0);
        chk("wd_err_cleared", err, 0);
`else
        chk("wd_err", err, 0);
        chk("wd_critical", critical, 1);
        chk("wd_busy", user_Busy, 1);
`endif
        user_Abort = 1'b1;
        @(negedge clk);
        user_Abort = 1'b0;
        chk("wd_exit_busy", user_Busy, 0);

        // randomized traffic checked by the model
        repeat (3000) begin
            user_Start = 1'($urandom % 6 == 0);
            user_NumLayers = ($urandom % 8 == 0) ? LW'(0) : LW'($urandom_range(1, 4));
            user_FirstSecond = 1'($urandom);
            proc_Done = 1'($urandom % 4 == 0);
            user_Abort = 1'($urandom % 50 == 0);
            rst = 1'($urandom % 700 == 0);
            @(negedge clk);
        end
        rst = 0; user_Start = 0; user_Abort = 0; proc_Done = 0;
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
